// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// A stall or an EX flush turns the captured instruction into a bubble; the data fields still capture their inputs.
module id_ex_register #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      IF_ID_RegisterRs1,
  input  logic [4:0]      IF_ID_RegisterRs2,
  input  logic [4:0]      IF_ID_RegisterRd,
  input  logic            IF_ID_UsesRs2,
  input  logic [XLEN-1:0] ID_ReadData1,
  input  logic [XLEN-1:0] ID_ReadData2,
  input  logic [XLEN-1:0] ID_Imm,
  input  logic [XLEN-1:0] ID_PC,
  input  logic            ID_RegWrite,
  input  logic            ID_MemRead,
  input  logic            ID_MemWrite,
  input  logic            ID_MemToReg,
  input  logic            ID_Branch,
  input  logic            ID_ALUSrc,
  input  logic [1:0]      ID_ALUOp,
  input  logic            ID_Valid,
  input  logic            EX_Flush,
  output logic [4:0]      ID_EX_RegisterRs1,
  output logic [4:0]      ID_EX_RegisterRs2,
  output logic [4:0]      ID_EX_RegisterRd,
  output logic [XLEN-1:0] ID_EX_ReadData1,
  output logic [XLEN-1:0] ID_EX_ReadData2,
  output logic [XLEN-1:0] ID_EX_Imm,
  output logic [XLEN-1:0] ID_EX_PC,
  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemToReg,
  output logic            ID_EX_Branch,
  output logic            ID_EX_ALUSrc,
  output logic [1:0]      ID_EX_ALUOp,
  output logic            ID_EX_Valid,
  output logic            Stall,
  output logic            PCWrite,
  output logic            IF_ID_Write,
  output logic [15:0]     StallCount
);

  logic        src_match;
  logic        bubble;
  logic [15:0] stall_cnt_q;

  // A flush kills the decode instruction, so it can never be the consumer of a load.
  always_comb begin
    src_match = (ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_RegisterRs2));
    Stall     = ID_EX_Valid && ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                ID_Valid && src_match && !EX_Flush;
  end

  assign PCWrite     = !Stall;
  assign IF_ID_Write = !Stall;
  assign bubble      = Stall || EX_Flush;
  assign StallCount  = stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ID_EX_RegisterRs1 <= '0;
      ID_EX_RegisterRs2 <= '0;
      ID_EX_ReadData1   <= '0;
      ID_EX_ReadData2   <= '0;
      ID_EX_Imm         <= '0;
      ID_EX_PC          <= '0;
    end else begin
      ID_EX_RegisterRs1 <= IF_ID_RegisterRs1;
      ID_EX_RegisterRs2 <= IF_ID_RegisterRs2;
      ID_EX_ReadData1   <= ID_ReadData1;
      ID_EX_ReadData2   <= ID_ReadData2;
      ID_EX_Imm         <= ID_Imm;
      ID_EX_PC          <= ID_PC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ID_EX_RegisterRd <= '0;
      ID_EX_RegWrite   <= 1'b0;
      ID_EX_MemRead    <= 1'b0;
      ID_EX_MemWrite   <= 1'b0;
      ID_EX_MemToReg   <= 1'b0;
      ID_EX_Branch     <= 1'b0;
      ID_EX_ALUSrc     <= 1'b0;
      ID_EX_ALUOp      <= 2'b00;
      ID_EX_Valid      <= 1'b0;
    end else if (bubble) begin
      ID_EX_RegisterRd <= '0;
      ID_EX_RegWrite   <= 1'b0;
      ID_EX_MemRead    <= 1'b0;
      ID_EX_MemWrite   <= 1'b0;
      ID_EX_MemToReg   <= 1'b0;
      ID_EX_Branch     <= 1'b0;
      ID_EX_ALUSrc     <= 1'b0;
      ID_EX_ALUOp      <= 2'b00;
      ID_EX_Valid      <= 1'b0;
    end else begin
      ID_EX_RegisterRd <= IF_ID_RegisterRd;
      ID_EX_RegWrite   <= ID_RegWrite;
      ID_EX_MemRead    <= ID_MemRead;
      ID_EX_MemWrite   <= ID_MemWrite;
      ID_EX_MemToReg   <= ID_MemToReg;
      ID_EX_Branch     <= ID_Branch;
      ID_EX_ALUSrc     <= ID_ALUSrc;
      ID_EX_ALUOp      <= ID_ALUOp;
      ID_EX_Valid      <= ID_Valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (Stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: directed decode vectors each carry hand-computed
// expectations, which a negedge monitor pops and compares against the DUT.
module tb_id_ex_register;

  logic        clk;
  logic        reset_n;
  logic [4:0]  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd;
  logic        IF_ID_UsesRs2;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_Branch, ID_ALUSrc;
  logic [1:0]  ID_ALUOp;
  logic        ID_Valid, EX_Flush;
  logic [4:0]  ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_Branch, ID_EX_ALUSrc;
  logic [1:0]  ID_EX_ALUOp;
  logic        ID_EX_Valid, Stall, PCWrite, IF_ID_Write;
  logic [15:0] StallCount;

  id_ex_register #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .IF_ID_RegisterRs1(IF_ID_RegisterRs1), .IF_ID_RegisterRs2(IF_ID_RegisterRs2),
    .IF_ID_RegisterRd(IF_ID_RegisterRd), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_Branch(ID_Branch), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .ID_Valid(ID_Valid), .EX_Flush(EX_Flush),
    .ID_EX_RegisterRs1(ID_EX_RegisterRs1), .ID_EX_RegisterRs2(ID_EX_RegisterRs2),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_ReadData1(ID_EX_ReadData1),
    .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_Valid(ID_EX_Valid), .Stall(Stall), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, ALUOp[1:0]}
  // lw = D4, add = 82, sw = 24, beq = 09
  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        u2;
    logic [7:0]  ctrl;
    logic        fl;
    logic [31:0] d;
    logic [4:0]  ers1, ers2, erd;
    logic [7:0]  ectrl;
    logic        ev;
    logic [31:0] ed;
    logic        es;
    logic [15:0] ecnt;
    int          idx;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic u2, input logic [7:0] ctrl,
                              input logic fl, input logic [31:0] d, input logic [4:0] ers1,
                              input logic [4:0] ers2, input logic [4:0] erd, input logic [7:0] ectrl,
                              input logic ev, input logic [31:0] ed, input logic es,
                              input logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u2 = u2; r.ctrl = ctrl; r.fl = fl; r.d = d;
    r.ers1 = ers1; r.ers2 = ers2; r.erd = erd; r.ectrl = ectrl; r.ev = ev; r.ed = ed;
    r.es = es; r.ecnt = ecnt; r.idx = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u2, input logic [7:0] ctrl,
                       input logic fl, input logic [31:0] d);
    ID_Valid = v; IF_ID_RegisterRs1 = rs1; IF_ID_RegisterRs2 = rs2; IF_ID_RegisterRd = rd;
    IF_ID_UsesRs2 = u2; EX_Flush = fl;
    {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_Branch, ID_ALUSrc, ID_ALUOp} = ctrl;
    ID_ReadData1 = d; ID_ReadData2 = d * 3; ID_Imm = d * 5; ID_PC = d << 4;
  endtask

  function automatic logic [7:0] act_ctrl();
    return {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
            ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp};
  endfunction

  // Monitor: every negedge with a pending expectation, compare the whole visible state.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("stall", e.idx, {31'd0, Stall}, {31'd0, e.es});
      chk("pcwrite", e.idx, {31'd0, PCWrite}, {31'd0, !e.es});
      chk("ifid_write", e.idx, {31'd0, IF_ID_Write}, {31'd0, !e.es});
      chk("rs1", e.idx, {27'd0, ID_EX_RegisterRs1}, {27'd0, e.ers1});
      chk("rs2", e.idx, {27'd0, ID_EX_RegisterRs2}, {27'd0, e.ers2});
      chk("rd", e.idx, {27'd0, ID_EX_RegisterRd}, {27'd0, e.erd});
      chk("ctrl", e.idx, {24'd0, act_ctrl()}, {24'd0, e.ectrl});
      chk("valid", e.idx, {31'd0, ID_EX_Valid}, {31'd0, e.ev});
      chk("data1", e.idx, ID_EX_ReadData1, e.ed);
      chk("data2", e.idx, ID_EX_ReadData2, e.ed * 3);
      chk("imm", e.idx, ID_EX_Imm, e.ed * 5);
      chk("pc", e.idx, ID_EX_PC, e.ed << 4);
      chk("stall_count", e.idx, {16'd0, StallCount}, {16'd0, e.ecnt});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //                v  rs1 rs2 rd  u2 ctrl  fl d        | ers1 ers2 erd ectrl ev ed      es cnt
    vecs.push_back(mk(1, 3,  4,  5,  1, 8'h82, 0, 32'h11,  0,  0, 0, 8'h00, 0, 32'h0,  0, 0));
    vecs.push_back(mk(1, 1,  0,  5,  0, 8'hD4, 0, 32'h20,  3,  4, 5, 8'h82, 1, 32'h11, 0, 0));
    vecs.push_back(mk(1, 5,  7,  6,  1, 8'h82, 0, 32'h30,  1,  0, 5, 8'hD4, 1, 32'h20, 1, 0));
    vecs.push_back(mk(1, 5,  7,  6,  1, 8'h82, 0, 32'h30,  5,  7, 0, 8'h00, 0, 32'h30, 0, 1));
    vecs.push_back(mk(0, 0,  0,  0,  0, 8'h00, 0, 32'h40,  5,  7, 6, 8'h82, 1, 32'h30, 0, 1));
    vecs.push_back(mk(1, 2,  0,  5,  0, 8'hD4, 0, 32'h50,  0,  0, 0, 8'h00, 0, 32'h40, 0, 1));
    vecs.push_back(mk(1, 9,  5,  8,  0, 8'h82, 0, 32'h60,  2,  0, 5, 8'hD4, 1, 32'h50, 0, 1));
    vecs.push_back(mk(1, 3,  0,  5,  0, 8'hD4, 0, 32'h70,  9,  5, 8, 8'h82, 1, 32'h60, 0, 1));
    vecs.push_back(mk(1, 10, 5,  0,  1, 8'h24, 0, 32'h80,  3,  0, 5, 8'hD4, 1, 32'h70, 1, 1));
    vecs.push_back(mk(1, 10, 5,  0,  1, 8'h24, 0, 32'h80,  10, 5, 0, 8'h00, 0, 32'h80, 0, 2));
    vecs.push_back(mk(1, 4,  0,  5,  0, 8'hD4, 0, 32'hA0,  10, 5, 0, 8'h24, 1, 32'h80, 0, 2));
    vecs.push_back(mk(1, 5,  1,  7,  1, 8'h82, 1, 32'hB0,  4,  0, 5, 8'hD4, 1, 32'hA0, 0, 2));
    vecs.push_back(mk(1, 1,  2,  3,  1, 8'h09, 0, 32'hC0,  5,  1, 0, 8'h00, 0, 32'hB0, 0, 2));
    vecs.push_back(mk(1, 1,  0,  0,  0, 8'hD4, 0, 32'hD0,  1,  2, 3, 8'h09, 1, 32'hC0, 0, 2));
    vecs.push_back(mk(1, 0,  0,  4,  1, 8'h82, 0, 32'hE0,  1,  0, 0, 8'hD4, 1, 32'hD0, 0, 2));
    vecs.push_back(mk(1, 1,  0,  6,  0, 8'hD4, 0, 32'hF0,  0,  0, 4, 8'h82, 1, 32'hE0, 0, 2));
    vecs.push_back(mk(1, 6,  0,  7,  0, 8'hD4, 0, 32'h100, 1,  0, 6, 8'hD4, 1, 32'hF0, 1, 2));
    vecs.push_back(mk(1, 6,  0,  7,  0, 8'hD4, 0, 32'h100, 6,  0, 0, 8'h00, 0, 32'h100, 0, 3));
    vecs.push_back(mk(0, 7,  0,  9,  0, 8'h82, 0, 32'h120, 6,  0, 7, 8'hD4, 1, 32'h100, 0, 3));
    vecs.push_back(mk(0, 0,  0,  0,  0, 8'h00, 0, 32'h0,   7,  0, 9, 8'h82, 0, 32'h120, 0, 3));

    // Reset held with a would-be hazard on the decode inputs.
    reset_n = 1'b0;
    drive(1, 5, 0, 6, 0, 8'h82, 0, 32'h0);
    #2;
    chk("rst_valid", -1, {31'd0, ID_EX_Valid}, 32'd0);
    chk("rst_stall", -1, {31'd0, Stall}, 32'd0);
    chk("rst_pcwrite", -1, {31'd0, PCWrite}, 32'd1);
    chk("rst_count", -1, {16'd0, StallCount}, 32'd0);
    drive(0, 0, 0, 0, 0, 8'h00, 0, 32'h0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      @(posedge clk);
      #1;
      e = vecs[i];
      e.idx = i;
      drive(e.v, e.rs1, e.rs2, e.rd, e.u2, e.ctrl, e.fl, e.d);
      sb.push_back(e);
    end
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    #1;
    chk("sb_drain", -2, sb.size(), 0);

    // Async reset asserted in the middle of a load-use stall.
    @(posedge clk); #1;
    drive(1, 1, 0, 5, 0, 8'hD4, 0, 32'h200);
    @(posedge clk); #1;
    drive(1, 5, 7, 6, 1, 8'h82, 0, 32'h210);
    #1;
    chk("pre_rst_stall", -3, {31'd0, Stall}, 32'd1);
    chk("pre_rst_valid", -3, {31'd0, ID_EX_Valid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", -4, {31'd0, ID_EX_Valid}, 32'd0);
    chk("arst_rd", -4, {27'd0, ID_EX_RegisterRd}, 32'd0);
    chk("arst_ctrl", -4, {24'd0, act_ctrl()}, 32'd0);
    chk("arst_data1", -4, ID_EX_ReadData1, 32'd0);
    chk("arst_count", -4, {16'd0, StallCount}, 32'd0);
    chk("arst_stall", -4, {31'd0, Stall}, 32'd0);
    chk("arst_pcwrite", -4, {31'd0, PCWrite}, 32'd1);
    chk("arst_ifid_write", -4, {31'd0, IF_ID_Write}, 32'd1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rd", -5, {27'd0, ID_EX_RegisterRd}, 32'd6);
    chk("post_rst_valid", -5, {31'd0, ID_EX_Valid}, 32'd1);
    chk("post_rst_ctrl", -5, {24'd0, act_ctrl()}, 32'h82);
    chk("post_rst_data1", -5, ID_EX_ReadData1, 32'h210);

    // Self-dependent load repeated: one stall every second cycle.
    drive(1, 5, 0, 5, 0, 8'hD4, 0, 32'h300);
    repeat (8) @(posedge clk);
    #1;
    chk("count_4", -6, {16'd0, StallCount}, 32'd4);
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFF0;
    #1 release dut.stall_cnt_q;
    repeat (28) @(posedge clk);
    #1;
    chk("count_fffe", -7, {16'd0, StallCount}, 32'hFFFE);
    chk("no_stall_phase", -7, {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    chk("stall_phase", -8, {31'd0, Stall}, 32'd1);
    chk("stall_pcwrite", -8, {31'd0, PCWrite}, 32'd0);
    @(posedge clk); #1;
    chk("count_ffff", -9, {16'd0, StallCount}, 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("count_sat_hold", -10, {16'd0, StallCount}, 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of all data/PC/immediate fields.
REQ-002 SHALL have port clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd  input  5 each  register specifiers of the instruction in decode.
REQ-005 SHALL have port IF_ID_UsesRs2  input  1  decode instruction reads rs2 (R/S/B types).
REQ-006 SHALL have ports ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC  input  XLEN each  decode operands, immediate, PC.
REQ-007 SHALL have ports ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_Branch, ID_ALUSrc  input  1 each; ID_ALUOp  input  2; ID_Valid  input  1  decode-stage control and validity.
REQ-008 SHALL have port EX_Flush  input  1  branch/jump resolved taken in EX; kill decode instruction.
REQ-009 SHALL have outputs ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd (5 each), ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC (XLEN each), ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_Branch, ID_EX_ALUSrc (1 each), ID_EX_ALUOp (2), ID_EX_Valid (1)  registered EX-stage fields consumed by forwarding unit and ALU.
REQ-010 SHALL have outputs Stall  1  load-use hazard detected; PCWrite  1  PC may update; IF_ID_Write  1  IF/ID register may update (all combinational).
REQ-011 SHALL have output StallCount  16  registered count of load-use stall cycles.

Function
REQ-012 Hazard: Stall SHALL be 1 iff ID_EX_Valid & ID_EX_MemRead & ID_EX_RegisterRd!=0 & ID_Valid & (ID_EX_RegisterRd==IF_ID_RegisterRs1 | (IF_ID_UsesRs2 & ID_EX_RegisterRd==IF_ID_RegisterRs2)) & !EX_Flush.
REQ-013 PCWrite and IF_ID_Write SHALL equal !Stall in the same cycle.
REQ-014 Normal advance (no Stall, no EX_Flush): all ID_* inputs and IF_ID_Register* SHALL be captured into the matching ID_EX_* outputs at the next edge; ID_EX_Valid <= ID_Valid; latency exactly 1 cycle.
REQ-015 Bubble (Stall=1 or EX_Flush=1): at next edge ID_EX_RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, Valid SHALL be 0 and ID_EX_ALUOp 2'b00; ID_EX_RegisterRd SHALL be 0; data, PC, Imm, Rs1, Rs2 fields SHALL still capture inputs.
REQ-016 EX_Flush SHALL take priority over Stall: Stall forced 0 (REQ-012), PCWrite=IF_ID_Write=1, bubble inserted.
REQ-017 Invalid decode (ID_Valid=0) SHALL never raise Stall and SHALL advance as a bubble-equivalent (Valid=0, controls captured but Valid gates downstream).
REQ-018 A load to x0 (ID_EX_RegisterRd=0) SHALL not stall.
REQ-019 Stall SHALL last exactly one cycle per load-use pair: the bubble clears ID_EX_MemRead, so the held decode instruction advances on the following edge.
REQ-020 Back-to-back loads where the second depends on the first SHALL stall once; the second load then advances normally.
REQ-021 StallCount SHALL increment by 1 at each edge where Stall=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-022 On reset_n=0, asynchronously, all ID_EX_* outputs SHALL be 0 and StallCount SHALL be 0.
REQ-023 During reset, Stall SHALL evaluate 0 (ID_EX_Valid=0), so PCWrite=IF_ID_Write=1.
REQ-024 Reset asserted mid-stall SHALL discard the bubble/held state; first edge after release captures decode inputs per REQ-014.

Verification
REQ-025 Advance: ID_Valid=1, Rs1=3, Rs2=4, Rd=5, ReadData1=0x11, RegWrite=1 -> next cycle ID_EX_RegisterRd=5, ID_EX_ReadData1=0x11, ID_EX_RegWrite=1, ID_EX_Valid=1, Stall=0.
REQ-026 Load-use: ID_EX holds lw x5 (MemRead=1, Valid=1); decode add x6,x5,x7 -> Stall=1, PCWrite=0, IF_ID_Write=0; next cycle ID_EX_Valid=0, RegWrite=0, Rd=0, StallCount=1; following cycle add captured, Stall=0.
REQ-027 Rs2-only dependency: lw x5 in EX; decode with Rs2=5, UsesRs2=0 -> Stall=0; UsesRs2=1 -> Stall=1.
REQ-028 Flush priority: load-use condition present and EX_Flush=1 -> Stall=0, PCWrite=1; next cycle all ID_EX controls 0, StallCount unchanged.
REQ-029 x0 and saturation: lw x0 in EX with decode Rs1=0 -> Stall=0; force 65536 stall cycles -> StallCount=16'hFFFF and holds.
REQ-030 Async reset: assert reset_n=0 between edges while ID_EX_Valid=1 -> outputs 0 immediately, StallCount=0, PCWrite=1.
